fifo_burst_rd_ctrl: RTL and testbench

//  Drains the 2048x32 sync FIFO in fixed-length bursts toward a memory write port
//  (DDR write channel). Watches FIFO fill level, requests a burst with address and length,

---
 rtl/fifo_burst_rd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fifo_burst_rd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: drains a sync FIFO in fixed-length bursts toward a
// memory write port. One frame per start pulse. Each burst is requested with
// an address and length. After the request is acknowledged, exactly that many
// words are popped and streamed out through a 2-entry skid buffer, so the
// stream can run at full rate even though the FIFO has one cycle of read latency.
module fifo_burst_rd_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 11,
  parameter int ADDR_WIDTH  = 28,
  parameter int LEN_WIDTH   = 8,
  parameter int BURST_LEN   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  input  logic [23:0]           frame_words,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]  fifo_level,
  output logic                  burst_req,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  burst_ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FW  = 24;
  localparam int LVW = DEPTH_WIDTH + 1;
  localparam logic [FW-1:0]        BURST_FW = FW'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0] BURST_LW = LEN_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_XFER, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [FW-1:0]                   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]            len_q, len_d;
  logic [LEN_WIDTH-1:0]            issued_q, issued_d;
  logic [LEN_WIDTH-1:0]            sent_q, sent_d;
  logic [1:0][DATA_WIDTH-1:0]      buf_q;
  logic                            wr_ptr_q, rd_ptr_q;
  logic [1:0]                      cnt_q;
  logic                            inflight_q;

  logic [LEN_WIDTH-1:0]            cur_len;
  logic                            level_ok;
  logic [2:0]                      occ;
  logic                            pop;
  logic                            rd_en;
  logic                            at_last;
  logic                            last_pop;

  // Length of the next burst: nominal, or whatever is left of the frame
  always_comb begin
    cur_len = BURST_LW;
    if (rem_q < BURST_FW) cur_len = rem_q[LEN_WIDTH-1:0];
  end

  assign level_ok  = (fifo_level >= LVW'(cur_len));
  // Words already owned by the read path: buffered plus the one still in the FIFO pipe
  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign out_valid = (state_q == S_XFER) && (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // With a full pipe, a pop in this same cycle frees the slot for a back-to-back read
  assign rd_en     = (state_q == S_XFER) && (issued_q != len_q) && !fifo_rd_empty &&
                     ((occ < 3'd2) || ((occ == 3'd2) && pop));
  assign at_last   = (sent_q == len_q - LEN_WIDTH'(1));
  assign last_pop  = pop && at_last;

  assign fifo_rd_en = rd_en;
  assign burst_req  = (state_q == S_REQ);
  assign burst_addr = (state_q == S_REQ) ? addr_q : '0;
  assign burst_len  = (state_q == S_REQ) ? len_q : '0;
  assign out_data   = out_valid ? buf_q[rd_ptr_q] : '0;
  assign out_last   = out_valid && at_last;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

  // Frame/burst sequencing and the per-burst issue/transfer counters
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = frame_base;
        rem_d   = frame_words;
        state_d = (frame_words == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: if (level_ok) begin
        len_d   = cur_len;
        state_d = S_REQ;
      end
      S_REQ: if (burst_ack) begin
        issued_d = '0;
        sent_d   = '0;
        state_d  = S_XFER;
      end
      S_XFER: begin
        if (rd_en) issued_d = issued_q + LEN_WIDTH'(1);
        if (pop)   sent_d   = sent_q + LEN_WIDTH'(1);
        if (last_pop) begin
          rem_d   = rem_q - FW'(len_q);
          addr_d  = addr_q + ADDR_WIDTH'(len_q);
          state_d = (rem_q == FW'(len_q)) ? S_DONE : S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      issued_q <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
    end
  end

  // Skid buffer: capture FIFO data one cycle after each pop, drain in order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Bench for fifo_burst_rd_ctrl: behavioural FIFO, randomized ready/ack
// drivers, a reference model of expected bursts and stream words, a table of
// frame scenarios, plus hand sequences for the zero-length frame and mid-burst reset.
module tb_fifo_burst_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] frame_base;
  logic [23:0] frame_words;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic [11:0] fifo_level;
  logic        burst_req;
  logic [27:0] burst_addr;
  logic [7:0]  burst_len;
  logic        burst_ack;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  fifo_burst_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
    .frame_words(frame_words), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_level(fifo_level), .burst_req(burst_req),
    .burst_addr(burst_addr), .burst_len(burst_len), .burst_ack(burst_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [27:0] base;
    int          words;
    int          prefill;
    bit          feed;
    bit          rmode;
    int          ackdly;
    bit          poke;
    int          nburst;
    int          lastlen;
  } vec_t;

  typedef struct {
    logic [27:0] a;
    int          l;
  } burst_t;

  vec_t        vecs[7];
  logic [31:0] fq[$];
  logic [31:0] exp_words[$];
  burst_t      exp_bursts[$];

  int n_chk = 0, n_fail = 0;
  int feed_left = 0, feed_cnt = 0, ack_dly = 0, req_age = 0;
  bit rmode = 1'b0, rd_s = 1'b0, mon_en = 1'b0, acked = 1'b0, req_prev = 1'b0;
  int widx = 0, cur_len_exp = 0, fd_count = 0, bursts_seen = 0, last_len_dut = 0;
  logic [27:0] req_addr;
  logic [7:0]  req_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 50) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word();
    logic [31:0] w;
    w = $urandom;
    fq.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic build_bursts(input logic [27:0] base, input int words);
    logic [27:0] a;
    int rem, l;
    a = base;
    rem = words;
    while (rem > 0) begin
      l = (rem < 64) ? rem : 64;
      exp_bursts.push_back('{a, l});
      a = a + 28'(l);
      rem -= l;
    end
  endtask

  // Checks made on the settled signals of the current cycle (called at negedge)
  task automatic monitor();
    if (fifo_rd_en) chk("rd_en_only_after_ack", 64'(acked), 64'd1);
    if (fifo_rd_en) chk("rd_en_while_empty", 64'(fifo_rd_empty), 64'd0);
    if (out_valid)  chk("valid_only_in_burst", 64'(acked), 64'd1);
    if (burst_req) begin
      if (!req_prev) begin
        if (exp_bursts.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          chk("burst_addr", 64'(burst_addr), 64'(exp_bursts[0].a));
          chk("burst_len", 64'(burst_len), 64'(exp_bursts[0].l));
          chk("level_ge_len", 64'(fifo_level >= 12'(burst_len)), 64'd1);
        end
        req_addr = burst_addr;
        req_len  = burst_len;
      end else begin
        chk("addr_stable", 64'(burst_addr), 64'(req_addr));
        chk("len_stable", 64'(burst_len), 64'(req_len));
      end
      if (burst_ack) begin
        bursts_seen++;
        last_len_dut = int'(burst_len);
        if (exp_bursts.size() > 0) begin
          cur_len_exp = exp_bursts[0].l;
          void'(exp_bursts.pop_front());
        end
        acked = 1'b1;
        widx  = 0;
      end
    end
    req_prev = burst_req;
    if (out_valid && out_ready) begin
      widx++;
      if (exp_words.size() == 0) chk("extra_word", 64'd1, 64'd0);
      else chk("out_data", 64'(out_data), 64'(exp_words.pop_front()));
      chk("out_last", 64'(out_last), 64'(widx == cur_len_exp));
      if (widx == cur_len_exp) acked = 1'b0;
    end
    if (frame_done) begin
      fd_count++;
      chk("done_after_all_words", 64'(exp_bursts.size() + exp_words.size() + int'(acked)), 64'd0);
    end
  endtask

  // One clock: FIFO model and drivers just after posedge, monitor at negedge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_s && fq.size() > 0) fifo_rd_data = fq.pop_front();
    if (feed_left > 0) begin
      feed_cnt++;
      if (feed_cnt >= 10) begin
        push_word();
        feed_cnt = 0;
        feed_left--;
      end
    end
    fifo_level    = 12'(fq.size());
    fifo_rd_empty = (fq.size() == 0);
    if (burst_req) req_age++; else req_age = 0;
    burst_ack = burst_req && (req_age > ack_dly);
    out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    if (mon_en) monitor();
    rd_s = fifo_rd_en;
  endtask

  task automatic run_frame(input vec_t v);
    int fd0, bs0, i;
    ack_dly = v.ackdly;
    rmode   = v.rmode;
    for (int k = 0; k < v.prefill; k++) push_word();
    feed_left = v.feed ? v.words : 0;
    feed_cnt  = 0;
    build_bursts(v.base, v.words);
    fd0 = fd_count;
    bs0 = bursts_seen;
    tick();
    frame_base  = v.base;
    frame_words = 24'(v.words);
    start = 1'b1;
    tick();
    start = 1'b0;
    frame_base  = 28'($urandom);
    frame_words = 24'($urandom_range(1, 5000));
    if (v.poke) begin
      repeat (3) tick();
      chk("busy_before_poke", 64'(busy), 64'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    i = 0;
    while (fd_count == fd0 && i < 8000) begin
      tick();
      i++;
    end
    repeat (4) tick();
    chk("frame_done_count", 64'(fd_count - fd0), 64'd1);
    chk("burst_count", 64'(bursts_seen - bs0), 64'(v.nburst));
    chk("last_burst_len", 64'(last_len_dut), 64'(v.lastlen));
    chk("words_left", 64'(exp_words.size()), 64'd0);
    chk("fifo_left", 64'(fq.size()), 64'd0);
    chk("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, "_burst_req"}, 64'(burst_req), 64'd0);
    chk({tag, "_burst_addr"}, 64'(burst_addr), 64'd0);
    chk({tag, "_burst_len"}, 64'(burst_len), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    int fd0, bs0, i;
    vecs[0] = '{28'h0000100, 128, 128, 1'b0, 1'b0, 0,  1'b1, 2, 64};
    vecs[1] = '{28'h0002000, 100, 100, 1'b0, 1'b0, 0,  1'b1, 2, 36};
    vecs[2] = '{28'h0000300, 64,  0,   1'b1, 1'b0, 0,  1'b1, 1, 64};
    vecs[3] = '{28'h0004000, 200, 200, 1'b0, 1'b1, 0,  1'b1, 4, 8};
    vecs[4] = '{28'h0000500, 70,  70,  1'b0, 1'b0, 20, 1'b1, 2, 6};
    vecs[5] = '{28'hFFFFFC0, 130, 130, 1'b0, 1'b1, 3,  1'b1, 3, 2};
    vecs[6] = '{28'h0000040, 1,   1,   1'b0, 1'b1, 0,  1'b0, 1, 1};

    rst_n = 1'b0; start = 1'b0; frame_base = '0; frame_words = '0;
    fifo_rd_data = '0; fifo_rd_empty = 1'b1; fifo_level = '0;
    burst_ack = 1'b0; out_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) run_frame(vecs[v]);

    // Zero-length frame: immediate frame_done, no request
    fd0 = fd_count;
    bs0 = bursts_seen;
    frame_base = 28'h123; frame_words = 24'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (fd_count == fd0 && i < 6) begin
      tick();
      i++;
    end
    chk("zero_frame_done_prompt", 64'(i <= 1), 64'd1);
    repeat (4) tick();
    chk("zero_frame_done_once", 64'(fd_count - fd0), 64'd1);
    chk("zero_frame_no_req", 64'(bursts_seen - bs0), 64'd0);

    // Reset in the middle of a burst
    rmode = 1'b0; ack_dly = 0;
    for (int k = 0; k < 128; k++) push_word();
    build_bursts(28'h0000800, 128);
    tick();
    frame_base = 28'h0000800; frame_words = 24'd128;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (!acked && i < 200) begin
      tick();
      i++;
    end
    chk("reached_xfer", 64'(acked), 64'd1);
    repeat (10) tick();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    fq.delete(); exp_words.delete(); exp_bursts.delete();
    acked = 1'b0; req_prev = 1'b0; rd_s = 1'b0; feed_left = 0;
    tick();
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_frame(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
